// File: rtl/nibble_sum_accumulator_if.sv
// Purpose: handshake bundle between the 4-bit adder stage, the nibble sum
//          accumulator and the consumer of the frame totals.
// Signals:
//   in_valid / in_ready   sample handshake (producer -> accumulator)
//   in_sum[3:0], in_c5    adder sum nibble and carry-out forming one sample
//   out_valid / out_ready frame result handshake (accumulator -> consumer)
//   out_acc[ACC_W-1:0]    frame total modulo 2**ACC_W
//   out_ovf               frame total did not fit in ACC_W bits
// Modports: master = producer/consumer side, slave = accumulator side.
interface nibble_sum_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             in_c5;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, in_c5, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_c5, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/nibble_sum_accumulator.sv
// Purpose: sums N_SAMPLES 5-bit adder results {c5,sum} per frame into an
//          ACC_W-bit total with a sticky overflow flag, holds the total on a
//          valid/ready output until taken, then starts the next frame.
// Ports:
//   clk  rising-edge clock
//   r    asynchronous active-high reset
//   clr  synchronous frame abort (drops any sample offered in that cycle)
//   bus  nibble_sum_accumulator_if.slave: sample input handshake and
//        registered frame result (out_valid, out_acc, out_ovf)
module nibble_sum_accumulator #(
  parameter int ACC_W     = 12,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic                    clr,
  nibble_sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // A one-sample frame completes directly from IDLE.
  localparam bit SINGLE = (N_SAMPLES == 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready_s;
  logic             accept_s;
  logic [ACC_W:0]   sample_s;
  logic [ACC_W:0]   base_s;
  logic [ACC_W:0]   sum_s;

  assign in_ready_s = (state_q != ST_HOLD);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign sample_s   = {{(ACC_W-4){1'b0}}, bus.in_c5, bus.in_sum};
  // IDLE starts a fresh frame, so the first sample is added to zero.
  assign base_s     = (state_q == ST_IDLE) ? {(ACC_W+1){1'b0}} : {1'b0, acc_q};
  // One extra bit catches the carry out of the accumulator for the sticky flag.
  assign sum_s      = base_s + sample_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

  // Next-state and next-datapath logic; clr overrides every state.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      state_d     = ST_IDLE;
      acc_d       = {ACC_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            acc_d = sum_s[ACC_W-1:0];
            cnt_d = CNT_W'(1);
            ovf_d = sum_s[ACC_W];
            if (SINGLE) begin
              state_d     = ST_HOLD;
              out_valid_d = 1'b1;
            end else begin
              state_d     = ST_ACCUM;
              out_valid_d = 1'b0;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_d = sum_s[ACC_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sum_s[ACC_W];
            // The result becomes visible on the same edge as the final sample.
            if (cnt_q == LAST_CNT) begin
              state_d     = ST_HOLD;
              out_valid_d = 1'b1;
            end else begin
              state_d     = ST_ACCUM;
              out_valid_d = 1'b0;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_d     = ST_IDLE;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_nibble_sum_accumulator.sv
// Bench for nibble_sum_accumulator: instance A uses the defaults
// (ACC_W=12, N_SAMPLES=8), instance B uses ACC_W=8, N_SAMPLES=16.
// Expected frame totals come from a plain integer sum of the samples sent.
module tb_nibble_sum_accumulator;

  logic clk = 1'b0;
  logic r;
  logic clr_a;
  logic clr_b;

  always #5 clk = ~clk;

  nibble_sum_accumulator_if #(.ACC_W(12)) bus_a ();
  nibble_sum_accumulator_if #(.ACC_W(8))  bus_b ();

  nibble_sum_accumulator #(.ACC_W(12), .N_SAMPLES(8), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .r   (r),
    .clr (clr_a),
    .bus (bus_a)
  );

  nibble_sum_accumulator #(.ACC_W(8), .N_SAMPLES(16), .CNT_W(8)) u_dut_b (
    .clk (clk),
    .r   (r),
    .clr (clr_b),
    .bus (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // One sample into A after optional bubbles; returns at posedge+1.
  task automatic send_a(input logic [4:0] s, input int bubbles, input string tag);
    for (int k = 0; k < bubbles; k++) begin
      @(negedge clk);
      bus_a.in_valid = 1'b0;
    end
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    {bus_a.in_c5, bus_a.in_sum} = s;
    n_tests++;
    if (bus_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready got %b exp 1", tag, bus_a.in_ready);
    end
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] s, input string tag);
    @(negedge clk);
    bus_b.in_valid = 1'b1;
    {bus_b.in_c5, bus_b.in_sum} = s;
    n_tests++;
    if (bus_b.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready got %b exp 1", tag, bus_b.in_ready);
    end
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
  endtask

  // Full frame into A: kind 0 = all 15, 1 = random 0..30, else all 2.
  task automatic frame_a(input int kind, input int max_bub, input string tag);
    int total;
    logic [4:0] s;
    logic [11:0] exp_acc;
    logic exp_ovf;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      case (kind)
        0:       s = 5'd15;
        1:       s = 5'($urandom_range(0, 30));
        default: s = 5'd2;
      endcase
      total += int'(s);
      send_a(s, (max_bub > 0) ? int'($urandom_range(0, max_bub)) : 0, tag);
      if (i < 7) begin
        n_tests++;
        if (bus_a.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early_valid sample %0d got %b exp 0", tag, i, bus_a.out_valid);
        end
      end
    end
    exp_acc = 12'(total % 4096);
    exp_ovf = (total > 4095);
    n_tests++;
    if (bus_a.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid got %b exp 1", tag, bus_a.out_valid);
    end
    n_tests++;
    if (bus_a.out_acc !== exp_acc) begin
      n_fail++;
      $display("FAIL %s out_acc got %h exp %h", tag, bus_a.out_acc, exp_acc);
    end
    n_tests++;
    if (bus_a.out_ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s out_ovf got %b exp %b", tag, bus_a.out_ovf, exp_ovf);
    end
  endtask

  // Sixteen copies of one value into B, then result check.
  task automatic frame_b(input logic [4:0] v, input string tag);
    int total;
    logic [7:0] exp_acc;
    logic exp_ovf;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      total += int'(v);
      send_b(v, tag);
      if (i < 15) begin
        n_tests++;
        if (bus_b.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early_valid sample %0d got %b exp 0", tag, i, bus_b.out_valid);
        end
      end
    end
    exp_acc = 8'(total % 256);
    exp_ovf = (total > 255);
    n_tests++;
    if (bus_b.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid got %b exp 1", tag, bus_b.out_valid);
    end
    n_tests++;
    if (bus_b.out_acc !== exp_acc) begin
      n_fail++;
      $display("FAIL %s out_acc got %h exp %h", tag, bus_b.out_acc, exp_acc);
    end
    n_tests++;
    if (bus_b.out_ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s out_ovf got %b exp %b", tag, bus_b.out_ovf, exp_ovf);
    end
  endtask

  // Take A's result; a sample is offered in the same cycle and must be ignored.
  task automatic release_a(input string tag);
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    {bus_a.in_c5, bus_a.in_sum} = 5'd30;
    @(posedge clk);
    #1;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b0;
    n_tests++;
    if ({bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf, bus_a.in_ready} !== {1'b0, 12'h000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s release got v=%b acc=%h ovf=%b rdy=%b exp v=0 acc=000 ovf=0 rdy=1",
               tag, bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf, bus_a.in_ready);
    end
  endtask

  task automatic release_b(input string tag);
    @(negedge clk);
    bus_b.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_b.out_ready = 1'b0;
    n_tests++;
    if ({bus_b.out_valid, bus_b.out_ovf, bus_b.in_ready} !== {1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s release got v=%b ovf=%b rdy=%b exp v=0 ovf=0 rdy=1",
               tag, bus_b.out_valid, bus_b.out_ovf, bus_b.in_ready);
    end
  endtask

  task automatic test_reset();
    r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf, bus_a.in_ready} !== {1'b0, 12'h000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_a got v=%b acc=%h ovf=%b rdy=%b exp v=0 acc=000 ovf=0 rdy=1",
               bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf, bus_a.in_ready);
    end
    n_tests++;
    if ({bus_b.out_valid, bus_b.out_acc, bus_b.out_ovf} !== {1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b got v=%b acc=%h ovf=%b exp v=0 acc=00 ovf=0",
               bus_b.out_valid, bus_b.out_acc, bus_b.out_ovf);
    end
    @(negedge clk);
    r = 1'b0;
  endtask

  task automatic test_back_to_back();
    frame_a(0, 0, "b2b");
    release_a("b2b");
  endtask

  task automatic test_overflow();
    frame_b(5'd30, "ovf_frame");
    release_b("ovf_rel");
    frame_b(5'd1, "ovf_next");
    release_b("ovf_next_rel");
  endtask

  task automatic test_backpressure();
    frame_a(0, 0, "bp_frame");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus_a.in_valid = 1'b1;
      {bus_a.in_c5, bus_a.in_sum} = 5'($urandom_range(0, 30));
      n_tests++;
      if ({bus_a.in_ready, bus_a.out_valid, bus_a.out_acc} !== {1'b0, 1'b1, 12'h078}) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got rdy=%b v=%b acc=%h exp rdy=0 v=1 acc=078",
                 k, bus_a.in_ready, bus_a.out_valid, bus_a.out_acc);
      end
    end
    release_a("bp_rel");
    frame_a(0, 0, "bp_next");
    release_a("bp_next_rel");
  endtask

  task automatic test_bubbles();
    frame_a(0, 3, "bubble_f");
    release_a("bubble_f_rel");
    for (int f = 0; f < 3; f++) begin
      frame_a(1, 3, "bubble_rand");
      release_a("bubble_rand_rel");
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) send_a(5'd5, 0, "clr_pre");
    @(negedge clk);
    clr_a = 1'b1;
    bus_a.in_valid = 1'b1;
    {bus_a.in_c5, bus_a.in_sum} = 5'd7;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    bus_a.in_valid = 1'b0;
    n_tests++;
    if ({bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf, bus_a.in_ready} !== {1'b0, 12'h000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL clr_accum got v=%b acc=%h ovf=%b rdy=%b exp v=0 acc=000 ovf=0 rdy=1",
               bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf, bus_a.in_ready);
    end
    frame_a(2, 0, "clr_next");
    // Abort in HOLD drops the result without a handshake.
    @(negedge clk);
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    n_tests++;
    if ({bus_a.out_valid, bus_a.out_acc, bus_a.in_ready} !== {1'b0, 12'h000, 1'b1}) begin
      n_fail++;
      $display("FAIL clr_hold got v=%b acc=%h rdy=%b exp v=0 acc=000 rdy=1",
               bus_a.out_valid, bus_a.out_acc, bus_a.in_ready);
    end
    frame_a(1, 1, "clr_after_hold");
    release_a("clr_after_hold_rel");
  endtask

  task automatic test_async_reset();
    frame_b(5'd30, "ar_frame_b");
    frame_a(0, 0, "ar_frame_a");
    @(negedge clk);
    #1;
    r = 1'b1;
    #1;
    n_tests++;
    if ({bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf} !== {1'b0, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL async_rst_a got v=%b acc=%h ovf=%b exp v=0 acc=000 ovf=0",
               bus_a.out_valid, bus_a.out_acc, bus_a.out_ovf);
    end
    n_tests++;
    if ({bus_b.out_valid, bus_b.out_acc, bus_b.out_ovf} !== {1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL async_rst_b got v=%b acc=%h ovf=%b exp v=0 acc=00 ovf=0",
               bus_b.out_valid, bus_b.out_acc, bus_b.out_ovf);
    end
    #1;
    r = 1'b0;
    #1;
    n_tests++;
    if ({bus_a.in_ready, bus_b.in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL async_rst_ready got a=%b b=%b exp a=1 b=1", bus_a.in_ready, bus_b.in_ready);
    end
    frame_a(0, 0, "ar_after");
    release_a("ar_after_rel");
  endtask

  initial begin
    r     = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_sum    = 4'h0;
    bus_a.in_c5     = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_sum    = 4'h0;
    bus_b.in_c5     = 1'b0;
    bus_b.out_ready = 1'b0;

    test_reset();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_clr();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
